// File: rtl/pygmy_lru8_state_pkg.sv
// Shared tree-PLRU helpers for 8-way sets.
// lru8_t layout: [6] root (1 = ways 0-3), [4] ways 0-3 node (1 = 0-1),
// [5] ways 4-7 node (1 = 4-5), [3:0] leaves (lru[k]=1 -> way 2k else 2k+1).
package pygmy_func;

  typedef logic [6:0] lru8_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } lru_state_t;

  // Retrain the tree so every node on the path to w points away from w.
  function automatic lru8_t lru8_touch(input lru8_t lru, input logic [2:0] w);
    lru8_t r;
    r = lru;
    r[6] = w[2];
    if (!w[2]) r[4] = w[1];
    else       r[5] = w[1];
    r[w[2:1]] = w[0];
    return r;
  endfunction

  // Returns {none, way_id}. An invalid enabled way wins outright; otherwise
  // walk the tree, steering away from any subtree with no enabled way.
  function automatic logic [3:0] lru8_victim(input lru8_t lru,
                                             input logic [7:0] valid,
                                             input logic [7:0] enable);
    logic [7:0] free;
    logic       found;
    logic       upper;
    logic       pair_hi;
    logic       odd;
    logic [3:0] sub;
    logic [1:0] pe;
    logic [2:0] way;
    logic       none;
    free  = ~valid & enable;
    found = 1'b0;
    way   = '0;
    none  = 1'b0;
    upper = 1'b0;
    pair_hi = 1'b0;
    odd   = 1'b0;
    sub   = '0;
    pe    = '0;
    if (enable == '0) begin
      none = 1'b1;
    end else if (free != '0) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (free[i] && !found) begin
          way   = i[2:0];
          found = 1'b1;
        end
      end
    end else begin
      upper = ~lru[6];
      if (upper && enable[7:4] == '0)       upper = 1'b0;
      else if (!upper && enable[3:0] == '0) upper = 1'b1;
      sub     = upper ? enable[7:4] : enable[3:0];
      pair_hi = upper ? ~lru[5] : ~lru[4];
      if (pair_hi && sub[3:2] == '0)       pair_hi = 1'b0;
      else if (!pair_hi && sub[1:0] == '0) pair_hi = 1'b1;
      pe  = pair_hi ? sub[3:2] : sub[1:0];
      odd = ~lru[{upper, pair_hi}];
      if (odd && !pe[1])       odd = 1'b0;
      else if (!odd && !pe[0]) odd = 1'b1;
      way = {upper, pair_hi, odd};
    end
    return {none, way};
  endfunction

endpackage

// File: rtl/pygmy_lru8_state_victim.sv
// Combinational victim selector for one 8-way PLRU set.
// Ports: lru (tree state), way_valid/way_enable (per-way masks),
//        way_id (chosen victim), none (no enabled way; way_id=0).
module pygmy_lru8_victim
  import pygmy_func::*;
(
  input  lru8_t      lru,
  input  logic [7:0] way_valid,
  input  logic [7:0] way_enable,
  output logic [2:0] way_id,
  output logic       none
);

  always_comb begin
    {none, way_id} = lru8_victim(lru, way_valid, way_enable);
  end

endmodule

// File: rtl/pygmy_lru8_state.sv
// Per-set tree-PLRU state store for an 8-way cache.
// Ports: clk/rst (async active-high); init_done after the reset sweep;
//        cfg_way_enable replacement mask; touch_* retrain a set's tree;
//        req_*/rsp_* victim query with 1-cycle latency and ready/valid on both sides.
module pygmy_lru8_state
  import pygmy_func::*;
#(
  parameter int    NUM_SETS  = 64,
  parameter int    SET_IDX_W = $clog2(NUM_SETS),
  parameter lru8_t LRU_RST   = 7'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic [7:0]           cfg_way_enable,
  input  logic                 touch_valid,
  input  logic [SET_IDX_W-1:0] touch_set_idx,
  input  logic [2:0]           touch_way_id,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SET_IDX_W-1:0] req_set_idx,
  input  logic [7:0]           req_way_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_way_id,
  output logic                 rsp_none
);

  localparam logic [SET_IDX_W-1:0] LAST_IDX = SET_IDX_W'(NUM_SETS - 1);

  lru_state_t           state_q, state_d;
  logic [SET_IDX_W-1:0] cnt_q;
  lru8_t                lru_mem [NUM_SETS];

  logic                 wr_en;
  logic [SET_IDX_W-1:0] wr_idx;
  lru8_t                wr_data;
  lru8_t                touch_lru;
  lru8_t                query_lru;
  logic                 touch_fire;
  logic                 accept;
  logic [2:0]           vic_way;
  logic                 vic_none;

  assign init_done  = (state_q == ST_RUN);
  assign req_ready  = init_done & (~rsp_valid | rsp_ready);
  assign accept     = req_valid & req_ready;
  assign touch_fire = touch_valid & init_done;

  // A same-cycle touch to the queried set is forwarded so the query sees
  // the post-touch tree.
  always_comb begin
    touch_lru = lru8_touch(lru_mem[touch_set_idx], touch_way_id);
    query_lru = lru_mem[req_set_idx];
    if (touch_fire && touch_set_idx == req_set_idx) query_lru = touch_lru;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = LRU_RST;
    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (touch_valid) begin
          wr_en   = 1'b1;
          wr_idx  = touch_set_idx;
          wr_data = touch_lru;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_way_id <= '0;
      rsp_none   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        rsp_valid  <= 1'b1;
        rsp_way_id <= vic_way;
        rsp_none   <= vic_none;
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

  // Storage has no reset: the init sweep establishes every entry.
  always_ff @(posedge clk) begin
    if (wr_en) lru_mem[wr_idx] <= wr_data;
  end

  pygmy_lru8_victim u_victim (
    .lru        (query_lru),
    .way_valid  (req_way_valid),
    .way_enable (cfg_way_enable),
    .way_id     (vic_way),
    .none       (vic_none)
  );

  touch_in_init: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_INIT) |-> !touch_valid);

endmodule
